instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'h0040_0000, the first fetch address after reset.
REQ-002 The block SHALL expose parameter DEPTH, default 2, the instruction buffer entry count; a power of two, at least 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port imem_req_valid, output, 1 bit: a fetch request is presented.
REQ-006 Port imem_req_addr, output, 32 bits: byte address of the requested word, bits[1:0] always 0.
REQ-007 Port imem_req_ready, input, 1 bit: the memory accepts the request this cycle.
REQ-008 Port imem_rsp_valid, input, 1 bit: a response word is present; it is never back-pressured.
REQ-009 Port imem_rsp_data, input, 32 bits: the instruction word returned.
REQ-010 Port instr_valid, output, 1 bit: an instruction is offered to decode.
REQ-011 Port instr, output, 32 bits: the instruction word; bits[31:26] feed the opcode decoder.
REQ-012 Port instr_pc, output, 32 bits: the address of instr.
REQ-013 Port instr_ready, input, 1 bit: decode accepts instr this cycle.
REQ-014 Port redirect_valid, input, 1 bit: a branch is taken (BEQ/BNE resolved) and fetch must restart.
REQ-015 Port redirect_pc, input, 32 bits: the new fetch address; bits[1:0] are ignored and treated as 0.

Function
REQ-016 Request transfers SHALL occur when imem_req_valid && imem_req_ready; response transfers when imem_rsp_valid; decode transfers when instr_valid && instr_ready.
REQ-017 Memory SHALL return responses in order, exactly one per accepted request, at least 1 cycle after acceptance.
REQ-018 fetch_pc SHALL advance by 4 on each accepted request, wrapping from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-019 imem_req_valid SHALL assert only in RUN, and only when buffer occupancy plus outstanding requests is less than DEPTH.
REQ-020 imem_req_valid and imem_req_addr SHALL remain stable until accepted, unless a redirect occurs.
REQ-021 A response accepted in RUN SHALL be written into the buffer together with the PC of its request.
REQ-022 instr_valid SHALL equal "buffer not empty"; instr and instr_pc SHALL be the oldest entry, held stable until consumed.
REQ-023 Throughput: with single-cycle memory and instr_ready held at 1, the block SHALL sustain one instruction per cycle after the first.
REQ-024 Buffer full with a response arriving: the condition is impossible under the credit rule of REQ-019, and an assertion SHALL flag it.
REQ-025 Simultaneous buffer write and read SHALL keep occupancy unchanged, including when the buffer is full.
REQ-026 The FSM SHALL have states RUN and DRAIN.
REQ-027 On redirect_valid in RUN:
- the buffer flushes;
- fetch_pc loads redirect_pc;
- the drop count loads the outstanding count, including any request accepted in the same cycle;
- a response arriving in the same cycle is discarded;
- next state is DRAIN if the drop count is nonzero, else RUN.
REQ-028 A decode transfer completing in the redirect cycle SHALL count as delivered.
REQ-029 In DRAIN:
- no requests issue;
- each response decrements the drop count and is discarded;
- the block returns to RUN in the cycle after the count reaches 0.
REQ-030 A redirect in DRAIN SHALL reload fetch_pc, keep the drop count, and remain in DRAIN.
REQ-031 The first request after a redirect SHALL carry redirect_pc.

Reset
REQ-032 On reset:
- state goes to RUN;
- fetch_pc loads RESET_PC;
- buffer, outstanding count and drop count clear;
- imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
REQ-033 Reset mid-operation SHALL abandon outstanding requests; the memory is reset in the same cycle and returns no stale responses.

Configuration
REQ-034 With macro FETCH_REDIRECT_EN defined, redirect behaves per REQ-027 to REQ-031.
REQ-035 Without FETCH_REDIRECT_EN:
- the redirect ports stay present but are ignored;
- no DRAIN state or drop counter is built;
- fetch is strictly sequential.

Structure
REQ-036 Shared package mips_pkg SHALL hold:
- opcode constants (R_TYPE 6'h00, ADDI 6'h08, ORI 6'h0D, LUI 6'h0F, LW 6'h23, SW 6'h2B, BEQ 6'h04, BNE 6'h05);
- the fetch FSM state enum;
- the RESET_PC default.
REQ-037 Sub-module fetch_fifo SHALL implement the DEPTH-entry {pc, instr} FIFO with synchronous flush.

Verification
REQ-038 Reset release, memory ready with 1-cycle latency, instr_ready=1 -> requests 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; instructions delivered one per cycle in address order.
REQ-039 instr_ready=0 for 10 cycles -> at most DEPTH requests outstanding or buffered; instr and instr_pc=0x00400000 held stable throughout.
REQ-040 Redirect to 0x00400100 with 2 responses outstanding -> both discarded, DRAIN for 2 responses, next request 0x00400100, no stale instruction delivered.
REQ-041 Redirect_pc=0x00400103 -> first request address 0x00400100.
REQ-042 RESET_PC=32'hFFFF_FFF8 -> request sequence FFFFFFF8, FFFFFFFC, 00000000.
REQ-043 Reset asserted with buffer full and 1 request outstanding -> next cycle instr_valid=0 and imem_req_valid=0; first request after release is RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcode constants, fetch FSM state,
// the default reset vector and the fetch buffer entry layout.
package mips_pkg;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ORI    = 6'h0D;
    localparam logic [5:0] LUI    = 6'h0F;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2B;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetchState_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetchEntry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {pc, instr} buffer between instruction memory and decode,
// with synchronous flush used on branch redirect.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wrEn,
    input  fetchEntry_t              wrData,
    input  logic                     rdEn,
    output fetchEntry_t              rdData,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetchEntry_t    mem [DEPTH];
    logic [AW-1:0]  wrPtr;
    logic [AW-1:0]  rdPtr;
    logic           doWr;
    logic           doRd;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign doRd  = rdEn && !empty;
    // A read in the same cycle frees the slot, so a full buffer still accepts.
    assign doWr  = wrEn && (!full || doRd);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doWr) wrPtr <= wrPtr + 1'b1;
            if (doRd) rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(doWr) - CW'(doRd);
        end
    end

    always_ff @(posedge clk) begin
        if (doWr) mem[wrPtr] <= wrData;
    end

    assign rdData = mem[rdPtr];

endmodule

// File: rtl/instruction_fetch.sv
// Sequential instruction fetch with credit-limited memory requests and a
// small in-order buffer. Branch redirect support is built with FETCH_REDIRECT_EN.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   fetchPc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] inFlightNext;
    logic [CW-1:0] bufCount;
    logic [CW:0]   credit;
    logic          bufEmpty;
    logic          bufFull;
    logic          bufWr;
    fetchEntry_t   bufIn;
    fetchEntry_t   bufHead;
    logic          reqFire;
    logic          decFire;
    logic          running;
    logic          redirect;

`ifdef FETCH_REDIRECT_EN
    fetchState_e   state;
    logic [CW-1:0] dropCnt;
    logic [CW-1:0] dropNext;
    logic          unusedPcBits;

    assign running      = (state == RUN);
    assign redirect     = redirect_valid;
    assign unusedPcBits = ^redirect_pc[1:0];
    assign dropNext     = dropCnt - CW'(imem_rsp_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            dropCnt <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (redirect_valid) begin
                        // Everything still in flight belongs to the abandoned path.
                        dropCnt <= inFlightNext;
                        if (inFlightNext != '0) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    dropCnt <= dropNext;
                    if (dropNext == '0) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
`else
    logic unusedRedirect;

    assign running        = 1'b1;
    assign redirect       = 1'b0;
    assign unusedRedirect = redirect_valid ^ (^redirect_pc);
`endif

    assign decFire = instr_valid && instr_ready;
    assign reqFire = imem_req_valid && imem_req_ready;

    // An entry leaving to decode this cycle frees a credit now, which keeps
    // single-cycle memory streaming at one instruction per cycle.
    assign credit         = {1'b0, bufCount} + {1'b0, outstanding} - {{CW{1'b0}}, decFire};
    assign imem_req_valid = !reset && running && (credit < DEPTH_W);
    assign imem_req_addr  = fetchPc;

    assign inFlightNext = outstanding + CW'(reqFire) - CW'(imem_rsp_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc     <= RESET_PC;
            outstanding <= '0;
        end else begin
            outstanding <= inFlightNext;
            if (redirect)     fetchPc <= {redirect_pc[31:2], 2'b00};
            else if (reqFire) fetchPc <= fetchPc + 32'd4;
        end
    end

    // In RUN the in-flight requests are consecutive words ending just below fetchPc.
    assign bufWr       = imem_rsp_valid && running && !redirect;
    assign bufIn.pc    = fetchPc - (32'(outstanding) << 2);
    assign bufIn.instr = imem_rsp_data;

    fetch_fifo #(.DEPTH(DEPTH)) buffer (
        .clk    (clk),
        .reset  (reset),
        .flush  (redirect),
        .wrEn   (bufWr),
        .wrData (bufIn),
        .rdEn   (decFire),
        .rdData (bufHead),
        .empty  (bufEmpty),
        .full   (bufFull),
        .count  (bufCount)
    );

    assign instr_valid = !bufEmpty;
    assign instr       = bufEmpty ? 32'h0 : bufHead.instr;
    assign instr_pc    = bufEmpty ? 32'h0 : bufHead.pc;

    bufNoOverflow: assert property (@(posedge clk) disable iff (reset)
        !(bufFull && imem_rsp_valid));

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_instruction_fetch;
    localparam logic [31:0] RPC     = 32'h0040_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        reqValid, reqReady = 1'b0, rspValid = 1'b0;
    logic [31:0] reqAddr, rspData = 32'h0;
    logic        instrValid, instrReady = 1'b0;
    logic [31:0] instr, instrPc;
    logic        redirValid = 1'b0;
    logic [31:0] redirPc = 32'h0;

    logic        wReqValid, wReqReady = 1'b0, wRspValid = 1'b0;
    logic [31:0] wReqAddr, wRspData = 32'h0;
    logic        wInstrValid, wInstrReady = 1'b0, wRedirValid = 1'b0;
    logic [31:0] wInstr, wInstrPc, wRedirPc = 32'h0;

    instruction_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(reqValid), .imem_req_addr(reqAddr), .imem_req_ready(reqReady),
        .imem_rsp_valid(rspValid), .imem_rsp_data(rspData),
        .instr_valid(instrValid), .instr(instr), .instr_pc(instrPc), .instr_ready(instrReady),
        .redirect_valid(redirValid), .redirect_pc(redirPc)
    );

    instruction_fetch #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dutWrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(wReqValid), .imem_req_addr(wReqAddr), .imem_req_ready(wReqReady),
        .imem_rsp_valid(wRspValid), .imem_rsp_data(wRspData),
        .instr_valid(wInstrValid), .instr(wInstr), .instr_pc(wInstrPc), .instr_ready(wInstrReady),
        .redirect_valid(wRedirValid), .redirect_pc(wRedirPc)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } pend_t;

    pend_t       pendQ[$];
    logic [31:0] bufQ[$];
    logic [31:0] expPc = RPC;
    int          latMin = 1, latMax = 1;
    int          accepted = 0, dropped = 0;

    logic        sReqValid, sInstrValid, sWReqValid;
    logic [31:0] sReqAddr, sInstrPc, sWReqAddr;
    logic        wFirePrev = 1'b0;
    logic [31:0] wAddrPrev = 32'h0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit anyDead();
        foreach (pendQ[i]) if (!pendQ[i].live) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive inputs, sample and check mid-cycle, then advance model.
    task automatic step(input logic rr, input logic ir, input logic rv,
                        input logic [31:0] rp, input bit rspAllow);
        bit          rsp, decFire = 1'b0, reqFire = 1'b0, redir = 1'b0, expValid;
        int          c = cyc;
        pend_t       p;
        logic [31:0] addrNow;
        rsp = rspAllow && !reset && (pendQ.size() > 0);
        if (rsp) rsp = (pendQ[0].due <= cyc);
        reqReady    = rr;
        instrReady  = ir;
        rspValid    = rsp;
        rspData     = rsp ? memWord(pendQ[0].addr) : $urandom();
        redirValid  = rv;
        redirPc     = rp;
        wReqReady   = 1'b1;
        wInstrReady = 1'b1;
        wRspValid   = wFirePrev && !reset;
        wRspData    = memWord(wAddrPrev);
        #1;
        sReqValid = reqValid; sReqAddr = reqAddr;
        sInstrValid = instrValid; sInstrPc = instrPc;
        sWReqValid = wReqValid; sWReqAddr = wReqAddr;
        addrNow = reqAddr;
        if (!reset) begin
            decFire = instrValid && ir;
            reqFire = reqValid && rr;
            check("instrValid", 32'(instrValid), 32'(bufQ.size() != 0));
            if (instrValid && bufQ.size() != 0) begin
                check("instrPc", instrPc, bufQ[0]);
                check("instrData", instr, memWord(bufQ[0]));
            end
            expValid = !anyDead() &&
                       ((int'(bufQ.size()) + int'(pendQ.size()) - (decFire ? 1 : 0)) < DEPTH);
            check("reqValid", 32'(reqValid), 32'(expValid));
            if (reqValid) check("reqAddr", reqAddr, expPc);
`ifdef FETCH_REDIRECT_EN
            redir = rv;
`endif
        end
        wFirePrev = wReqValid && !reset;
        wAddrPrev = wReqAddr;
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            pendQ.delete();
            bufQ.delete();
            expPc = RPC;
            wFirePrev = 1'b0;
        end else begin
            if (decFire) void'(bufQ.pop_front());
            if (reqFire) begin
                pendQ.push_back('{addrNow, c + $urandom_range(latMax, latMin), 1'b1});
                expPc += 32'd4;
                accepted++;
            end
            if (rsp) begin
                p = pendQ.pop_front();
                if (p.live && !redir) bufQ.push_back(p.addr);
                else dropped++;
            end
            if (redir) begin
                bufQ.delete();
                foreach (pendQ[i]) pendQ[i].live = 1'b0;
                expPc = {rp[31:2], 2'b00};
            end
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("rst.reqValid", 32'(reqValid), 32'h0);
        check("rst.instrValid", 32'(instrValid), 32'h0);
        check("rst.instr", instr, 32'h0);
        check("rst.instrPc", instrPc, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        accepted = 0;
        dropped = 0;
    endtask

    typedef struct {
        logic        rr;
        logic        ir;
        logic        eReqValid;
        logic [31:0] eAddr;
        logic        eInstrValid;
        logic [31:0] ePc;
        logic [31:0] eWAddr;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int   n;
        bit   ok;
        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h0040_0000, 1'b0, 32'h0,          32'hFFFF_FFF8};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h0040_0004, 1'b0, 32'h0,          32'hFFFF_FFFC};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h0040_0008, 1'b1, 32'h0040_0000, 32'h0000_0000};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0040_000C, 1'b1, 32'h0040_0004, 32'h0000_0004};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0008, 32'h0000_0008};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0040_0014, 1'b1, 32'h0040_000C, 32'h0000_000C};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h0040_0014, 1'b1, 32'h0040_0010, 32'h0000_0010};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h0040_0018, 1'b0, 32'h0,          32'h0000_0014};

        // Streaming from reset, plus the wrapping reset vector on the second instance.
        doReset();
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].rr, vecs[i].ir, 1'b0, 32'h0, 1'b1);
            check($sformatf("vec%0d.reqValid", i), 32'(sReqValid), 32'(vecs[i].eReqValid));
            if (vecs[i].eReqValid) check($sformatf("vec%0d.reqAddr", i), sReqAddr, vecs[i].eAddr);
            check($sformatf("vec%0d.instrValid", i), 32'(sInstrValid), 32'(vecs[i].eInstrValid));
            if (vecs[i].eInstrValid) check($sformatf("vec%0d.instrPc", i), sInstrPc, vecs[i].ePc);
            check($sformatf("vec%0d.wrapValid", i), 32'(sWReqValid), 32'h1);
            check($sformatf("vec%0d.wrapAddr", i), sWReqAddr, vecs[i].eWAddr);
        end

        // Decode stalled: credits cap in-flight work, head entry held.
        doReset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            check("stall.credit", 32'(int'(bufQ.size() + pendQ.size()) <= DEPTH), 32'h1);
            if (sInstrValid) check("stall.headPc", sInstrPc, RPC);
        end
        check("stall.accepted", accepted, DEPTH);
        check("stall.headValid", 32'(instrValid), 32'h1);
        n = 0;
        while ((bufQ.size() != 0 || pendQ.size() != 0) && n < 40) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            n++;
        end
        check("stall.drained", 32'(bufQ.size() + pendQ.size()), 32'h0);

        // Reset while one entry is buffered and one request is in flight.
        doReset();
        latMin = 4; latMax = 4;
        n = 0;
        while (!(bufQ.size() == 1 && pendQ.size() == 1) && n < 20) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            n++;
        end
        check("midRst.setup", n < 20, 32'h1);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("midRst.instrValid", 32'(instrValid), 32'h0);
        check("midRst.reqValid", 32'(reqValid), 32'h0);
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("midRst.firstReq", sReqValid ? sReqAddr : 32'hDEAD_BEEF, RPC);

`ifdef FETCH_REDIRECT_EN
        // Redirect with two responses in flight: both dropped, then new path.
        doReset();
        latMin = 3; latMax = 3;
        n = 0;
        while (pendQ.size() != 2 && n < 20) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            n++;
        end
        check("redir.setup", 32'(pendQ.size()), 32'h2);
        step(1'b0, 1'b1, 1'b1, 32'h0040_0100, 1'b0);
        n = 0;
        ok = 1'b0;
        while (!ok && n < 20) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            if (sReqValid) ok = 1'b1;
            else n++;
        end
        check("redir.drainCycles", n, 2);
        check("redir.dropped", dropped, 2);
        check("redir.firstReq", sReqAddr, 32'h0040_0100);

        // Unaligned redirect target is fetched word-aligned.
        doReset();
        latMin = 1; latMax = 1;
        step(1'b0, 1'b1, 1'b1, 32'h0040_0103, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("redirAlign.valid", 32'(sReqValid), 32'h1);
        check("redirAlign.addr", sReqAddr, 32'h0040_0100);
`else
        // Redirect inputs have no effect in the sequential-only build.
        doReset();
        latMin = 1; latMax = 1;
        step(1'b0, 1'b1, 1'b1, 32'h0040_0103, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("noRedir.valid", 32'(sReqValid), 32'h1);
        check("noRedir.addr", sReqAddr, RPC);
`endif

        // Randomized traffic with occasional mid-run resets.
        doReset();
        for (int blk = 0; blk < 6; blk++) begin
            int rrPct, irPct, rspPct, rvPct;
            latMin = $urandom_range(2, 1);
            latMax = latMin + $urandom_range(3, 0);
            rrPct  = $urandom_range(100, 30);
            irPct  = $urandom_range(100, 20);
            rspPct = $urandom_range(100, 40);
            rvPct  = $urandom_range(8, 2);
            if (blk == 3) doReset();
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(99, 0) < rrPct, $urandom_range(99, 0) < irPct,
                     $urandom_range(99, 0) < rvPct,
                     32'h0040_0000 | ($urandom() & 32'h0000_0FFF),
                     $urandom_range(99, 0) < rspPct);
            end
        end
        n = 0;
        while ((bufQ.size() != 0 || pendQ.size() != 0) && n < 60) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            n++;
        end
        check("final.drained", 32'(bufQ.size() + pendQ.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
